pipe_bus_ctrl: RTL and testbench
================================

// Module: pipe_bus_ctrl
// PURPOSE
//  Pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
//  - Arbitrates the single shared memory bus between instruction fetch and the mem stage.
//  - Generates stall[5:0] for all pipeline registers: stall[1]=1 with stall[2]=0 makes the if/id register insert a bubble.
//  - Sequences the exception/eret flush and supplies the redirect PC.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0020  redirect PC for exceptions (non-eret)
//  TIMEOUT     255            cycles a transfer may wait for bus_ack before abort; 1..255
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  stallreq_id    in   1   id stage hazard stall request
//  stallreq_ex    in   1   ex stage multi-cycle stall request
//  if_bus_req     in   1   fetch wants bus; held until if_bus_done
//  if_bus_addr    in   32  fetch address
//  mem_bus_req    in   1   mem stage wants bus; held until mem_bus_done
//  mem_bus_addr   in   32  data address
//  mem_bus_we     in   1   data write enable
//  bus_ack        in   1   bus completes current transfer this cycle
//  except_valid   in   1   mem stage reports exception/eret (level)
//  except_eret    in   1   qualifies except_valid: 1 = eret
//  cp0_epc        in   32  eret return address
//  bus_req        out  1   transfer active on bus
//  bus_addr       out  32  latched transfer address
//  bus_we         out  1   latched write enable (0 for fetch)
//  if_bus_done    out  1   one-cycle pulse: fetch transfer finished
//  mem_bus_done   out  1   one-cycle pulse: data transfer finished
//  bus_timeout    out  1   one-cycle pulse alongside done when aborted
//  stall          out  6   per-stage hold vector, combinational
//  flush          out  1   one-cycle pipeline flush
//  new_pc         out  32  redirect PC, valid while flush=1
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs, timeout counter and flush_pending cleared.
//  Reset mid-transfer drops bus_req at that edge; the transfer is abandoned with no done pulse.
//  States:
//   IDLE      bus idle.
//             Eligible requester: req=1 and its own done not high this cycle.
//             Priority: flush_pending -> FLUSH; else mem eligible -> MEM_XFER; else if eligible -> IF_XFER.
//   IF_XFER   bus_req=1, bus_we=0. bus_addr is latched from the requester at the grant edge.
//   MEM_XFER  bus_req=1. bus_addr and bus_we are latched from the requester at the grant edge.
//             XFER exit: on bus_ack, or when the counter reaches TIMEOUT -> IDLE.
//             Next cycle: that requester's done=1. bus_timeout=1 too if aborted.
//             IF_XFER suppresses if_bus_done when flush_pending is set; the fetch data is discarded.
//   FLUSH     flush=1 for exactly 1 cycle, then IDLE. flush_pending is cleared on exit.
//  Minimum transfer: req in cycle 0, grant edge, bus_req in cycle 1, ack in cycle 1, done in cycle 2.
//  Timeout counter: 8 bits, cleared on every grant, incremented each XFER cycle without ack.
//  Exception capture:
//   except_valid=1 with flush_pending=0 and state!=FLUSH sets flush_pending.
//   new_pc is latched on that edge: except_eret ? cp0_epc : EXC_VECTOR.
//   Further except_valid is ignored until FLUSH exits.
//   A transfer in progress always completes (ack/timeout) before FLUSH.
//  stall, first match wins:
//   flush=1                                    -> 6'b000000
//   flush_pending=1                            -> 6'b111111
//   mem_bus_req and !mem_bus_done              -> 6'b011111
//   stallreq_ex                                -> 6'b001111
//   stallreq_id                                -> 6'b000111
//   if_bus_req and !if_bus_done                -> 6'b000011
//   else                                       -> 6'b000000
//  Simultaneous if and mem requests: mem is served first, then fetch on the next IDLE cycle.
//  bus_ack seen in IDLE or FLUSH is ignored.
// TESTING
//  mem_bus_req=1 addr=0x100 we=1, ack 3 cycles after grant
//    -> bus_addr=0x100 bus_we=1; stall=011111 until mem_bus_done pulses once; then stall=000000.
//  if and mem requests raised in the same cycle
//    -> MEM_XFER first; IF_XFER granted 1 cycle after mem_bus_done; stall 011111 then 000011.
//  except_valid=1 eret=0 in IDLE
//    -> stall=111111 for 1 cycle, then flush=1 with new_pc=0x20 and stall=000000 for 1 cycle.
//  except_valid=1 eret=1 epc=0x400 during IF_XFER, ack 2 cycles later
//    -> no if_bus_done; FLUSH follows with new_pc=0x400.
//  TIMEOUT=4, no ack -> abort after 4 XFER cycles; done and bus_timeout pulse together.
//  rst asserted during MEM_XFER -> next cycle bus_req=0, stall=000000, no done pulse.

Source files
------------

// File: rtl/pipe_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_bus_ctrl_if
//   Shared memory-bus handshake between the pipeline sequencer, the two bus
//   requesters (instruction fetch and mem stage) and the memory itself.
//
//   Requester side (driven toward the controller):
//     if_bus_req / if_bus_addr               fetch request, held until if_bus_done
//     mem_bus_req / mem_bus_addr / mem_bus_we data request, held until mem_bus_done
//     bus_ack                                memory completes current transfer
//   Controller side (driven by pipe_bus_ctrl):
//     bus_req / bus_addr / bus_we            transfer currently on the bus
//     if_bus_done / mem_bus_done             one-cycle completion pulses
//     bus_timeout                            one-cycle pulse with done on abort
//
//   Modports:
//     master  the controller (pipe_bus_ctrl)
//     slave   requesters plus memory
// ---------------------------------------------------------------------------
interface pipe_bus_ctrl_if;
  logic        if_bus_req;
  logic [31:0] if_bus_addr;
  logic        mem_bus_req;
  logic [31:0] mem_bus_addr;
  logic        mem_bus_we;
  logic        bus_ack;

  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        if_bus_done;
  logic        mem_bus_done;
  logic        bus_timeout;

  modport master (
    input  if_bus_req, if_bus_addr, mem_bus_req, mem_bus_addr, mem_bus_we, bus_ack,
    output bus_req, bus_addr, bus_we, if_bus_done, mem_bus_done, bus_timeout
  );

  modport slave (
    output if_bus_req, if_bus_addr, mem_bus_req, mem_bus_addr, mem_bus_we, bus_ack,
    input  bus_req, bus_addr, bus_we, if_bus_done, mem_bus_done, bus_timeout
  );
endinterface

// File: rtl/pipe_bus_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_bus_ctrl
//   Pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
//   - Arbitrates the single shared memory bus between instruction fetch and
//     the mem stage (mem has priority).
//   - Generates the per-stage hold vector stall[5:0]. stall[1]=1 with
//     stall[2]=0 makes the if/id register insert a bubble.
//   - Sequences the exception / eret flush and supplies the redirect PC.
//
// Parameters
//   EXC_VECTOR  redirect PC for exceptions that are not eret
//   TIMEOUT     cycles a transfer may wait for bus_ack before abort (1..255)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   stallreq_id     id-stage hazard stall request
//   stallreq_ex     ex-stage multi-cycle stall request
//   bus             pipe_bus_ctrl_if.master (requests, bus, done pulses)
//   except_valid    mem stage reports exception/eret (level)
//   except_eret     qualifies except_valid: 1 = eret
//   cp0_epc         eret return address
//   stall[5:0]      per-stage hold vector (combinational)
//   flush           one-cycle pipeline flush (registered)
//   new_pc          redirect PC, valid while flush=1 (registered)
// ---------------------------------------------------------------------------
module pipe_bus_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  pipe_bus_ctrl_if.master        bus,
  input  logic                   except_valid,
  input  logic                   except_eret,
  input  logic [31:0]            cp0_epc,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [31:0]            new_pc
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_XFER  = 2'd1,
    ST_MEM_XFER = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  // Counter value seen in the last permitted wait cycle: a transfer that has
  // not been acked by the end of its TIMEOUT-th bus cycle is aborted.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       flush_pending;

  logic       if_eligible;
  logic       mem_eligible;
  logic       xfer_abort;
  logic       xfer_end;
  logic       exc_capture;

  // A requester keeps its req high during the cycle its done pulses, so it
  // must not be granted again in that cycle.
  assign if_eligible  = bus.if_bus_req  & ~bus.if_bus_done;
  assign mem_eligible = bus.mem_bus_req & ~bus.mem_bus_done;

  // Ack on the last permitted cycle wins over the abort.
  assign xfer_abort   = ~bus.bus_ack & (tmo_cnt == TMO_LAST);
  assign xfer_end     = bus.bus_ack | xfer_abort;

  // One exception is captured at a time; the FLUSH cycle itself is blind so
  // the level-sensitive request from the flushed mem stage is not re-taken.
  assign exc_capture  = except_valid & ~flush_pending & (state != ST_FLUSH);

  // NOTE: every register below is assigned with <= so all of them update
  // together from the values present before the edge; blocking assignments
  // here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and only touches control/status flops; the
    // block holds no storage arrays, so nothing needs a reset loop.
    if (rst) begin
      state            <= ST_IDLE;
      tmo_cnt          <= 8'd0;
      flush_pending    <= 1'b0;
      flush            <= 1'b0;
      new_pc           <= 32'd0;
      bus.bus_req      <= 1'b0;
      bus.bus_addr     <= 32'd0;
      bus.bus_we       <= 1'b0;
      bus.if_bus_done  <= 1'b0;
      bus.mem_bus_done <= 1'b0;
      bus.bus_timeout  <= 1'b0;
    end else begin
      // Pulse outputs default low; the branches below raise them for a cycle.
      bus.if_bus_done  <= 1'b0;
      bus.mem_bus_done <= 1'b0;
      bus.bus_timeout  <= 1'b0;
      flush            <= 1'b0;

      if (exc_capture) begin
        flush_pending <= 1'b1;
        new_pc        <= except_eret ? cp0_epc : EXC_VECTOR;
      end

      case (state)
        ST_IDLE: begin
          if (flush_pending) begin
            state <= ST_FLUSH;
            flush <= 1'b1;
          end else if (mem_eligible) begin
            state        <= ST_MEM_XFER;
            bus.bus_req  <= 1'b1;
            bus.bus_addr <= bus.mem_bus_addr;
            bus.bus_we   <= bus.mem_bus_we;
            tmo_cnt      <= 8'd0;
          end else if (if_eligible) begin
            state        <= ST_IF_XFER;
            bus.bus_req  <= 1'b1;
            bus.bus_addr <= bus.if_bus_addr;
            bus.bus_we   <= 1'b0;
            tmo_cnt      <= 8'd0;
          end
        end

        ST_IF_XFER, ST_MEM_XFER: begin
          if (xfer_end) begin
            state       <= ST_IDLE;
            bus.bus_req <= 1'b0;
            if (state == ST_MEM_XFER) begin
              bus.mem_bus_done <= 1'b1;
              bus.bus_timeout  <= xfer_abort;
            end else if (!flush_pending) begin
              // A fetch that overlaps a pending flush is discarded silently.
              bus.if_bus_done <= 1'b1;
              bus.bus_timeout <= xfer_abort;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        ST_FLUSH: begin
          state         <= ST_IDLE;
          flush_pending <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Hold vector, highest priority first. Bit n holds stage n
  // (0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb).
  // NOTE: stall gets a default before the if-chain so every path assigns it
  // and no latch is inferred.
  always_comb begin
    stall = 6'b000000;
    if (flush)
      stall = 6'b000000;
    else if (flush_pending)
      stall = 6'b111111;
    else if (bus.mem_bus_req && !bus.mem_bus_done)
      stall = 6'b011111;
    else if (stallreq_ex)
      stall = 6'b001111;
    else if (stallreq_id)
      stall = 6'b000111;
    else if (bus.if_bus_req && !bus.if_bus_done)
      stall = 6'b000011;
  end

endmodule

// File: tb/tb_pipe_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_bus_ctrl
//   Cycle-by-cycle vector table for pipe_bus_ctrl (TIMEOUT=4), followed by
//   hand-written sequences for the fetch timeout and the ack-on-last-cycle
//   boundary. Inputs change 1 ns after the rising edge; outputs are sampled
//   on the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_pipe_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex;
  logic        except_valid, except_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  pipe_bus_ctrl_if bif ();

  pipe_bus_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .TIMEOUT    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .bus          (bif.master),
    .except_valid (except_valid),
    .except_eret  (except_eret),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rst, sid, sex, ireq;
    logic [31:0] iaddr;
    logic        mreq;
    logic [31:0] maddr;
    logic        mwe, ack, exv, eret;
    logic [31:0] epc;
    logic        e_breq;
    logic [31:0] e_baddr;
    logic        e_bwe, e_idone, e_mdone, e_tmo;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_newpc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(
    input string n,
    input logic r, input logic sid, input logic sex,
    input logic ireq, input logic [31:0] ia,
    input logic mreq, input logic [31:0] ma, input logic mwe,
    input logic ack, input logic exv, input logic eret, input logic [31:0] epc,
    input logic breq, input logic [31:0] baddr, input logic bwe,
    input logic idone, input logic mdone, input logic tmo,
    input logic [5:0] st, input logic fl, input logic [31:0] npc);
    vec_t v;
    v.name = n; v.rst = r; v.sid = sid; v.sex = sex; v.ireq = ireq; v.iaddr = ia;
    v.mreq = mreq; v.maddr = ma; v.mwe = mwe; v.ack = ack; v.exv = exv;
    v.eret = eret; v.epc = epc; v.e_breq = breq; v.e_baddr = baddr; v.e_bwe = bwe;
    v.e_idone = idone; v.e_mdone = mdone; v.e_tmo = tmo; v.e_stall = st;
    v.e_flush = fl; v.e_newpc = npc;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    stallreq_id = 0; stallreq_ex = 0; except_valid = 0; except_eret = 0; cp0_epc = 0;
    bif.if_bus_req = 0; bif.if_bus_addr = 0; bif.mem_bus_req = 0;
    bif.mem_bus_addr = 0; bif.mem_bus_we = 0; bif.bus_ack = 0;
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    rst = v.rst; stallreq_id = v.sid; stallreq_ex = v.sex;
    bif.if_bus_req = v.ireq; bif.if_bus_addr = v.iaddr;
    bif.mem_bus_req = v.mreq; bif.mem_bus_addr = v.maddr; bif.mem_bus_we = v.mwe;
    bif.bus_ack = v.ack; except_valid = v.exv; except_eret = v.eret; cp0_epc = v.epc;
    @(negedge clk);
    check({v.name, ".bus_req"},      bif.bus_req,      v.e_breq);
    check({v.name, ".bus_addr"},     bif.bus_addr,     v.e_baddr);
    check({v.name, ".bus_we"},       bif.bus_we,       v.e_bwe);
    check({v.name, ".if_bus_done"},  bif.if_bus_done,  v.e_idone);
    check({v.name, ".mem_bus_done"}, bif.mem_bus_done, v.e_mdone);
    check({v.name, ".bus_timeout"},  bif.bus_timeout,  v.e_tmo);
    check({v.name, ".stall"},        stall,            v.e_stall);
    check({v.name, ".flush"},        flush,            v.e_flush);
    check({v.name, ".new_pc"},       new_pc,           v.e_newpc);
  endtask

  int busy;
  bit seen;

  initial begin
    //   name   rst id ex ireq iaddr  mreq maddr  we ack exv eret epc   | breq baddr  we id md to stall      fl new_pc
    add("rst",  1, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h000, 0, 0, 0, 0, 6'b000000, 0, 'h00);
    // data write, ack on third bus cycle
    add("a0",   0, 0, 0, 0, 'h000, 1, 'h100, 1, 0, 0, 0, 'h000,   0, 'h000, 0, 0, 0, 0, 6'b011111, 0, 'h00);
    add("a1",   0, 0, 0, 0, 'h000, 1, 'h100, 1, 0, 0, 0, 'h000,   1, 'h100, 1, 0, 0, 0, 6'b011111, 0, 'h00);
    add("a2",   0, 0, 0, 0, 'h000, 1, 'h100, 1, 0, 0, 0, 'h000,   1, 'h100, 1, 0, 0, 0, 6'b011111, 0, 'h00);
    add("a3",   0, 0, 0, 0, 'h000, 1, 'h100, 1, 1, 0, 0, 'h000,   1, 'h100, 1, 0, 0, 0, 6'b011111, 0, 'h00);
    add("a4",   0, 0, 0, 0, 'h000, 1, 'h100, 1, 0, 0, 0, 'h000,   0, 'h100, 1, 0, 1, 0, 6'b000000, 0, 'h00);
    add("a5",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h100, 1, 0, 0, 0, 6'b000000, 0, 'h00);
    // simultaneous fetch and data request: mem first, then fetch
    add("b0",   0, 0, 0, 1, 'h200, 1, 'h300, 0, 0, 0, 0, 'h000,   0, 'h100, 1, 0, 0, 0, 6'b011111, 0, 'h00);
    add("b1",   0, 0, 0, 1, 'h200, 1, 'h300, 0, 1, 0, 0, 'h000,   1, 'h300, 0, 0, 0, 0, 6'b011111, 0, 'h00);
    add("b2",   0, 0, 0, 1, 'h200, 1, 'h300, 0, 0, 0, 0, 'h000,   0, 'h300, 0, 0, 1, 0, 6'b000011, 0, 'h00);
    add("b3",   0, 0, 0, 1, 'h200, 0, 'h000, 0, 1, 0, 0, 'h000,   1, 'h200, 0, 0, 0, 0, 6'b000011, 0, 'h00);
    add("b4",   0, 0, 0, 1, 'h200, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h200, 0, 1, 0, 0, 6'b000000, 0, 'h00);
    add("b5",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b000000, 0, 'h00);
    // exception in IDLE; stall priorities; ack during FLUSH ignored
    add("e0",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 1, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b000000, 0, 'h00);
    add("e1",   0, 1, 1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b111111, 0, 'h20);
    add("e2",   0, 0, 1, 0, 'h000, 0, 'h000, 0, 1, 0, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b000000, 1, 'h20);
    add("e3",   0, 1, 1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b001111, 0, 'h20);
    add("e4",   0, 1, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b000111, 0, 'h20);
    add("e5",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b000000, 0, 'h20);
    // eret during fetch: fetch completes silently, then FLUSH to epc
    add("f0",   0, 0, 0, 1, 'h500, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h200, 0, 0, 0, 0, 6'b000011, 0, 'h20);
    add("f1",   0, 0, 0, 1, 'h500, 0, 'h000, 0, 0, 1, 1, 'h400,   1, 'h500, 0, 0, 0, 0, 6'b000011, 0, 'h20);
    add("f2",   0, 0, 0, 1, 'h500, 0, 'h000, 0, 0, 1, 0, 'h000,   1, 'h500, 0, 0, 0, 0, 6'b111111, 0, 'h400);
    add("f3",   0, 0, 0, 1, 'h500, 0, 'h000, 0, 1, 0, 0, 'h000,   1, 'h500, 0, 0, 0, 0, 6'b111111, 0, 'h400);
    add("f4",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h500, 0, 0, 0, 0, 6'b111111, 0, 'h400);
    add("f5",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h500, 0, 0, 0, 0, 6'b000000, 1, 'h400);
    add("f6",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h500, 0, 0, 0, 0, 6'b000000, 0, 'h400);
    // data transfer never acked: abort after 4 bus cycles
    add("g0",   0, 0, 0, 0, 'h000, 1, 'h600, 1, 0, 0, 0, 'h000,   0, 'h500, 0, 0, 0, 0, 6'b011111, 0, 'h400);
    add("g1",   0, 0, 0, 0, 'h000, 1, 'h600, 1, 0, 0, 0, 'h000,   1, 'h600, 1, 0, 0, 0, 6'b011111, 0, 'h400);
    add("g2",   0, 0, 0, 0, 'h000, 1, 'h600, 1, 0, 0, 0, 'h000,   1, 'h600, 1, 0, 0, 0, 6'b011111, 0, 'h400);
    add("g3",   0, 0, 0, 0, 'h000, 1, 'h600, 1, 0, 0, 0, 'h000,   1, 'h600, 1, 0, 0, 0, 6'b011111, 0, 'h400);
    add("g4",   0, 0, 0, 0, 'h000, 1, 'h600, 1, 0, 0, 0, 'h000,   1, 'h600, 1, 0, 0, 0, 6'b011111, 0, 'h400);
    add("g5",   0, 0, 0, 0, 'h000, 1, 'h600, 1, 0, 0, 0, 'h000,   0, 'h600, 1, 0, 1, 1, 6'b000000, 0, 'h400);
    add("g6",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h600, 1, 0, 0, 0, 6'b000000, 0, 'h400);
    // reset mid-transfer; stray ack in IDLE afterwards
    add("h0",   0, 0, 0, 0, 'h000, 1, 'h700, 0, 0, 0, 0, 'h000,   0, 'h600, 1, 0, 0, 0, 6'b011111, 0, 'h400);
    add("h1",   1, 0, 0, 0, 'h000, 1, 'h700, 0, 0, 0, 0, 'h000,   1, 'h700, 0, 0, 0, 0, 6'b011111, 0, 'h400);
    add("h2",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h000, 0, 0, 0, 0, 6'b000000, 0, 'h00);
    add("h3",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 1, 0, 0, 'h000,   0, 'h000, 0, 0, 0, 0, 6'b000000, 0, 'h00);
    add("h4",   0, 0, 0, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 'h000,   0, 'h000, 0, 0, 0, 0, 6'b000000, 0, 'h00);

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);

    foreach (vecs[i]) apply(vecs[i]);

    // Fetch never acked: count bus cycles until the done pulse (bounded).
    @(posedge clk); #1;
    bif.if_bus_req = 1; bif.if_bus_addr = 32'h800;
    busy = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bif.if_bus_done) seen = 1;
      else if (bif.bus_req) busy++;
    end
    check("if_tmo.done_seen",   32'(seen), 1);
    check("if_tmo.bus_timeout", bif.bus_timeout, 1);
    check("if_tmo.xfer_cycles", busy, 4);
    check("if_tmo.bus_addr",    bif.bus_addr, 32'h800);
    check("if_tmo.bus_we",      bif.bus_we, 0);
    @(posedge clk); #1;
    bif.if_bus_req = 0;
    @(negedge clk);
    check("if_tmo.done_clears", bif.if_bus_done, 0);
    check("if_tmo.tmo_clears",  bif.bus_timeout, 0);

    // Ack on the last permitted cycle completes normally, no timeout.
    @(posedge clk); #1;
    bif.mem_bus_req = 1; bif.mem_bus_addr = 32'h900; bif.mem_bus_we = 0;
    repeat (4) @(posedge clk);
    #1 bif.bus_ack = 1;
    @(negedge clk);
    check("ack_last.bus_req",  bif.bus_req, 1);
    check("ack_last.bus_addr", bif.bus_addr, 32'h900);
    @(posedge clk); #1;
    bif.bus_ack = 0;
    @(negedge clk);
    check("ack_last.mem_done",    bif.mem_bus_done, 1);
    check("ack_last.bus_timeout", bif.bus_timeout, 0);
    check("ack_last.bus_req_low", bif.bus_req, 0);
    @(posedge clk); #1;
    bif.mem_bus_req = 0;
    @(negedge clk);
    check("ack_last.done_clears", bif.mem_bus_done, 0);
    check("ack_last.stall",       stall, 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
